// File: rtl/count_display_mux_if.sv
// Bus between the upstream 4-bit counter and the two-digit seven-segment driver.
// The counter drives Count; the display driver returns the segment, anode and decimal point lines.
interface count_display_mux_if;
  logic [3:0] Count;
  logic [6:0] Seg;
  logic [1:0] An;
  logic       Dp;

  modport master (output Count, input Seg, An, Dp);
  modport slave  (input Count, output Seg, An, Dp);
endinterface

// File: rtl/count_display_mux.sv
// Time-multiplexed two-digit common-anode driver for a 0..15 count.
// The count is sampled once per frame, so a digit never changes while the frame is being shown.
module count_display_mux #(
  parameter int REFRESH_DIV   = 50000,
  parameter bit LEADING_BLANK = 1'b1
) (
  input logic               Clk,
  input logic               Reset,
  count_display_mux_if.slave bus
);

  localparam int            RW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] LAST = RW'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_DARK = 7'h7F;
  localparam logic [1:0] AN_OFF   = 2'b11;
  localparam logic [1:0] AN_UNITS = 2'b10;
  localparam logic [1:0] AN_TENS  = 2'b01;

  logic [RW-1:0] ref_cnt;
  logic          sel;
  logic [3:0]    count_reg;
  logic          frame_end;

  logic          tens;
  logic [3:0]    units;
  logic [6:0]    seg_p0;
  logic [1:0]    an_p0;

  logic [6:0]    seg_p1;
  logic [1:0]    an_p1;
  logic          dp_p1;

  function automatic logic [6:0] encode(input logic [3:0] digit);
    logic [6:0] s;
    case (digit)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_DARK;
    endcase
    return s;
  endfunction

  assign frame_end = sel && (ref_cnt == LAST);

  // Stage p0: digit split and phase selection from the frame-stable sample.
  always_comb begin
    tens   = (count_reg >= 4'd10);
    units  = tens ? (count_reg - 4'd10) : count_reg;
    seg_p0 = SEG_DARK;
    an_p0  = AN_OFF;
    if (!sel) begin
      seg_p0 = encode(units);
      an_p0  = AN_UNITS;
    end else if (tens) begin
      seg_p0 = encode(4'd1);
      an_p0  = AN_TENS;
    end else if (!LEADING_BLANK) begin
      seg_p0 = encode(4'd0);
      an_p0  = AN_TENS;
    end
  end

  // Stage p1: registered outputs; anode and segment lines switch on the same edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ref_cnt   <= '0;
      sel       <= 1'b0;
      count_reg <= 4'd0;
      seg_p1    <= SEG_DARK;
      an_p1     <= AN_OFF;
      dp_p1     <= 1'b1;
    end else begin
      if (ref_cnt == LAST) begin
        ref_cnt <= '0;
        sel     <= ~sel;
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
      end
      if (frame_end)
        count_reg <= bus.Count;
      seg_p1 <= seg_p0;
      an_p1  <= an_p0;
      dp_p1  <= 1'b1;
    end
  end

  assign bus.Seg = seg_p1;
  assign bus.An  = an_p1;
  assign bus.Dp  = dp_p1;

endmodule

// File: tb/tb_count_display_mux.sv
// Bench for count_display_mux with REFRESH_DIV=4, one instance per LEADING_BLANK setting.
// Expected per-cycle outputs are queued as each frame is driven and popped after every clock edge.
module tb_count_display_mux;

  localparam int RD = 4;

  logic clk;
  logic rst;
  logic [3:0] count;

  count_display_mux_if bus1 ();
  count_display_mux_if bus0 ();

  assign bus1.Count = count;
  assign bus0.Count = count;

  count_display_mux #(.REFRESH_DIV(RD), .LEADING_BLANK(1'b1)) dut1 (
    .Clk(clk), .Reset(rst), .bus(bus1)
  );
  count_display_mux #(.REFRESH_DIV(RD), .LEADING_BLANK(1'b0)) dut0 (
    .Clk(clk), .Reset(rst), .bus(bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] count;
    logic [6:0] useg;
    logic [6:0] tseg1;
    logic [1:0] tan1;
    logic [6:0] tseg0;
    logic [1:0] tan0;
  } vec_t;

  vec_t tbl [16];
  logic [6:0] lut [10];

  logic [9:0] q1 [$];
  logic [9:0] q0 [$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [6:0] cur_u, cur_t1, cur_t0;
  logic [1:0] cur_a1, cur_a0;

  task automatic set_model(input logic [3:0] v);
    logic t;
    logic [3:0] u;
    t      = (v >= 4'd10);
    u      = t ? v - 4'd10 : v;
    cur_u  = lut[u];
    cur_t1 = t ? 7'h79 : 7'h7F;
    cur_a1 = t ? 2'b01 : 2'b11;
    cur_t0 = t ? 7'h79 : 7'h40;
    cur_a0 = 2'b01;
  endtask

  task automatic push_reset();
    q1.push_back({7'h7F, 2'b11, 1'b1});
    q0.push_back({7'h7F, 2'b11, 1'b1});
  endtask

  task automatic push_cycle(input bit tens_phase);
    if (!tens_phase) begin
      q1.push_back({cur_u, 2'b10, 1'b1});
      q0.push_back({cur_u, 2'b10, 1'b1});
    end else begin
      q1.push_back({cur_t1, cur_a1, 1'b1});
      q0.push_back({cur_t0, cur_a0, 1'b1});
    end
  endtask

  task automatic tick();
    logic [9:0] exp;
    logic [9:0] act;
    @(posedge clk);
    #1;
    cyc++;
    vectors++;
    act = {bus1.Seg, bus1.An, bus1.Dp};
    if (q1.size() == 0) begin
      miscompares++;
      $display("FAIL blank1 cycle %0d: scoreboard empty, got seg=%h an=%b dp=%b", cyc, act[9:3], act[2:1], act[0]);
    end else begin
      exp = q1.pop_front();
      if (act !== exp) begin
        miscompares++;
        $display("FAIL blank1 cycle %0d: got seg=%h an=%b dp=%b, want seg=%h an=%b dp=%b",
                 cyc, act[9:3], act[2:1], act[0], exp[9:3], exp[2:1], exp[0]);
      end
    end
    vectors++;
    act = {bus0.Seg, bus0.An, bus0.Dp};
    if (q0.size() == 0) begin
      miscompares++;
      $display("FAIL noblank cycle %0d: scoreboard empty, got seg=%h an=%b dp=%b", cyc, act[9:3], act[2:1], act[0]);
    end else begin
      exp = q0.pop_front();
      if (act !== exp) begin
        miscompares++;
        $display("FAIL noblank cycle %0d: got seg=%h an=%b dp=%b, want seg=%h an=%b dp=%b",
                 cyc, act[9:3], act[2:1], act[0], exp[9:3], exp[2:1], exp[0]);
      end
    end
  endtask

  initial begin
    logic [3:0] fr;
    logic [3:0] last;

    lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    tbl[0]  = '{4'd7,  7'h78, 7'h7F, 2'b11, 7'h40, 2'b01};
    tbl[1]  = '{4'd13, 7'h30, 7'h79, 2'b01, 7'h79, 2'b01};
    tbl[2]  = '{4'd4,  7'h19, 7'h7F, 2'b11, 7'h40, 2'b01};
    tbl[3]  = '{4'd0,  7'h40, 7'h7F, 2'b11, 7'h40, 2'b01};
    tbl[4]  = '{4'd9,  7'h10, 7'h7F, 2'b11, 7'h40, 2'b01};
    tbl[5]  = '{4'd10, 7'h40, 7'h79, 2'b01, 7'h79, 2'b01};
    tbl[6]  = '{4'd15, 7'h12, 7'h79, 2'b01, 7'h79, 2'b01};
    tbl[7]  = '{4'd1,  7'h79, 7'h7F, 2'b11, 7'h40, 2'b01};
    tbl[8]  = '{4'd2,  7'h24, 7'h7F, 2'b11, 7'h40, 2'b01};
    tbl[9]  = '{4'd3,  7'h30, 7'h7F, 2'b11, 7'h40, 2'b01};
    tbl[10] = '{4'd5,  7'h12, 7'h7F, 2'b11, 7'h40, 2'b01};
    tbl[11] = '{4'd6,  7'h02, 7'h7F, 2'b11, 7'h40, 2'b01};
    tbl[12] = '{4'd8,  7'h00, 7'h7F, 2'b11, 7'h40, 2'b01};
    tbl[13] = '{4'd11, 7'h79, 7'h79, 2'b01, 7'h79, 2'b01};
    tbl[14] = '{4'd14, 7'h19, 7'h79, 2'b01, 7'h79, 2'b01};
    tbl[15] = '{4'd12, 7'h24, 7'h79, 2'b01, 7'h79, 2'b01};

    // Reset held for three cycles with a nonzero count upstream.
    rst   = 1'b1;
    count = 4'd9;
    for (int i = 0; i < 3; i++) begin
      push_reset();
      tick();
    end
    rst = 1'b0;
    set_model(4'd0);

    // Each table value is held for a full frame and appears in the frame after.
    for (int i = 0; i < 16; i++) begin
      for (int c = 0; c < 2 * RD; c++) begin
        push_cycle(c >= RD);
        count = tbl[i].count;
        tick();
      end
      cur_u  = tbl[i].useg;
      cur_t1 = tbl[i].tseg1;
      cur_a1 = tbl[i].tan1;
      cur_t0 = tbl[i].tseg0;
      cur_a0 = tbl[i].tan0;
    end

    // Frame showing 12 while count moves to 5 during its units phase.
    for (int c = 0; c < 2 * RD; c++) begin
      push_cycle(c >= RD);
      count = (c < 2) ? 4'd12 : 4'd5;
      tick();
    end
    set_model(4'd5);

    // A transient 3 between sample points must never reach the display.
    for (int c = 0; c < 2 * RD; c++) begin
      push_cycle(c >= RD);
      count = (c >= 2 && c <= 5) ? 4'd3 : 4'd5;
      tick();
    end
    set_model(4'd5);

    for (int c = 0; c < 2 * RD; c++) begin
      push_cycle(c >= RD);
      count = 4'd15;
      tick();
    end
    set_model(4'd15);

    // Reset during the tens phase of a frame showing 15.
    for (int c = 0; c <= RD; c++) begin
      push_cycle(c >= RD);
      tick();
    end
    rst = 1'b1;
    push_reset();
    tick();
    rst = 1'b0;
    set_model(4'd0);

    for (int c = 0; c < 2 * RD; c++) begin
      push_cycle(c >= RD);
      count = 4'd15;
      tick();
    end
    set_model(4'd15);

    // Free-running upstream counter: only the value present at the frame end is shown.
    fr   = 4'd0;
    last = 4'd0;
    for (int f = 0; f < 7; f++) begin
      for (int c = 0; c < 2 * RD; c++) begin
        push_cycle(c >= RD);
        count = fr;
        last  = fr;
        tick();
        fr = fr + 4'd1;
      end
      set_model(last);
    end

    for (int c = 0; c < 2 * RD; c++) begin
      push_cycle(c >= RD);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
